// File: rtl/stream_packer.sv
// stream_packer: packs RATIO consecutive narrow valid/ready beats into one wide word.
// Lane 0 holds the first beat. A flush request emits a partially filled word, with its
// lane count on count_o. The output is registered and its handshake matches the skid
// buffer's input, so the two can be chained directly.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_clk_i     synchronous active-high reset
//   data_i        input beat payload (DATA_SIZE bits)
//   data_valid_i  input beat valid
//   data_ready_o  input beat ready
//   flush_i       single-cycle request to emit the partial word
//   data_o        packed word; lane k = data_o[k*DATA_SIZE +: DATA_SIZE]
//   count_o       number of valid lanes in data_o (1..RATIO); qualified by data_valid_o
//   data_valid_o  output word valid
//   data_ready_i  downstream ready
module stream_packer #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned RATIO     = 4,
  localparam int unsigned CNT_W    = $clog2(RATIO + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_clk_i,
  input  logic [DATA_SIZE-1:0]        data_i,
  input  logic                        data_valid_i,
  output logic                        data_ready_o,
  input  logic                        flush_i,
  output logic [DATA_SIZE*RATIO-1:0]  data_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        data_valid_o,
  input  logic                        data_ready_i
);

  localparam int unsigned WordW = DATA_SIZE * RATIO;

  logic [WordW-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flush_pend;
  logic [WordW-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;

  logic [WordW-1:0] w_acc_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_pend_d;
  logic [WordW-1:0] w_data_d;
  logic [CNT_W-1:0] w_count_d;
  logic             w_valid_d;

  logic             w_slot_free;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_p;
  logic [WordW-1:0] w_acc_beat;

  // The output register can take a new word this cycle.
  assign w_slot_free = !r_valid || data_ready_i;
  assign w_last      = (r_cnt == CNT_W'(RATIO - 1));
  // Only the final lane needs the output slot, so data_ready_i reaches data_ready_o
  // combinationally on that path alone.
  assign w_ready     = !r_flush_pend && (!w_last || w_slot_free);
  assign w_accept    = data_valid_i && w_ready;
  // Partial count including a beat accepted this cycle.
  assign w_p         = r_cnt + CNT_W'(w_accept);

  // Accumulator with the current beat (if accepted) placed in lane r_cnt.
  always_comb begin
    w_acc_beat = r_acc;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (w_accept && (r_cnt == CNT_W'(k))) begin
        w_acc_beat[k*DATA_SIZE +: DATA_SIZE] = data_i;
      end
    end
  end

  always_comb begin
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_pend_d  = r_flush_pend;
    w_data_d  = r_data;
    w_count_d = r_count;
    w_valid_d = r_valid && !data_ready_i;

    if (r_flush_pend) begin
      // Input is blocked while waiting, so r_acc already holds the whole partial word.
      if (w_slot_free) begin
        w_data_d  = r_acc;
        w_count_d = r_cnt;
        w_valid_d = 1'b1;
        w_acc_d   = '0;
        w_cnt_d   = '0;
        w_pend_d  = 1'b0;
      end
    end else if (w_accept && w_last) begin
      // Full word; a coincident flush is absorbed. Slot is free because ready was high.
      w_data_d  = w_acc_beat;
      w_count_d = CNT_W'(RATIO);
      w_valid_d = 1'b1;
      w_acc_d   = '0;
      w_cnt_d   = '0;
    end else if (flush_i && (w_p != '0)) begin
      if (w_slot_free) begin
        // Cleared accumulator guarantees unfilled lanes are zero.
        w_data_d  = w_acc_beat;
        w_count_d = w_p;
        w_valid_d = 1'b1;
        w_acc_d   = '0;
        w_cnt_d   = '0;
      end else begin
        w_acc_d  = w_acc_beat;
        w_cnt_d  = w_p;
        w_pend_d = 1'b1;
      end
    end else if (w_accept) begin
      w_acc_d = w_acc_beat;
      w_cnt_d = w_p;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_data       <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_acc        <= w_acc_d;
      r_cnt        <= w_cnt_d;
      r_flush_pend <= w_pend_d;
      r_data       <= w_data_d;
      r_count      <= w_count_d;
      r_valid      <= w_valid_d;
    end
  end

  assign data_ready_o = w_ready;
  assign data_o       = r_data;
  assign count_o      = r_count;
  assign data_valid_o = r_valid;

endmodule

// File: tb/tb_stream_packer.sv
// Testbench for stream_packer (DATA_SIZE=8, RATIO=4): directed scenarios checked
// against explicit expected words, then randomized traffic checked cycle by cycle
// against a queue-based reference model.
module tb_stream_packer;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned CW    = $clog2(RATIO + 1);
  localparam int unsigned WW    = DW * RATIO;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          dv;
  logic          rdy_o;
  logic          fl;
  logic [WW-1:0] dout;
  logic [CW-1:0] cnt_o;
  logic          vld_o;
  logic          dr;

  int n_checks;
  int n_pass;
  logic pre_ready;

  // Reference model state
  logic [DW-1:0] m_part[$];
  logic          m_pend;
  logic          m_valid;
  logic [WW-1:0] m_word;
  int            m_count;

  stream_packer #(
    .DATA_SIZE(DW),
    .RATIO    (RATIO)
  ) dut (
    .clk_i       (clk),
    .rst_clk_i   (rst),
    .data_i      (din),
    .data_valid_i(dv),
    .data_ready_o(rdy_o),
    .flush_i     (fl),
    .data_o      (dout),
    .count_o     (cnt_o),
    .data_valid_o(vld_o),
    .data_ready_i(dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_ready();
    return !m_pend && ((m_part.size() != RATIO - 1) || !m_valid || dr);
  endfunction

  task automatic model_emit();
    m_word = '0;
    foreach (m_part[i]) m_word[i*DW +: DW] = m_part[i];
    m_count = m_part.size();
    m_valid = 1'b1;
    m_part.delete();
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic sf;
    logic acc_b;
    if (rst) begin
      m_part.delete();
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_word  = '0;
      m_count = 0;
      return;
    end
    sf    = !m_valid || dr;
    acc_b = dv && model_ready();
    if (m_valid && dr) m_valid = 1'b0;
    if (m_pend) begin
      if (sf) begin
        model_emit();
        m_pend = 1'b0;
      end
    end else begin
      if (acc_b) m_part.push_back(din);
      if (m_part.size() == RATIO) model_emit();
      else if (fl && m_part.size() > 0) begin
        if (sf) model_emit();
        else m_pend = 1'b1;
      end
    end
  endtask

  // Apply inputs, sample ready before the edge, clock once, settle after the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
    dv  = v;
    din = d;
    fl  = f;
    dr  = r;
    #1;
    pre_ready = rdy_o;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (vld_o !== 1'b0) $display("FAIL reset_valid got %b want 0", vld_o);
    else n_pass++;
    n_checks++;
    if (dout !== '0) $display("FAIL reset_data got %h want 0", dout);
    else n_pass++;
    n_checks++;
    if (cnt_o !== '0) $display("FAIL reset_count got %0d want 0", cnt_o);
    else n_pass++;
    #1;
    n_checks++;
    if (rdy_o !== 1'b1) $display("FAIL reset_ready got %b want 1", rdy_o);
    else n_pass++;
  endtask

  task automatic test_full_stream();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b1);
      n_checks++;
      if (pre_ready !== 1'b1) $display("FAIL full_ready beat %0d got %b want 1", i, pre_ready);
      else n_pass++;
      if (i == 4 || i == 8) begin
        n_checks++;
        if (vld_o !== 1'b1 || cnt_o !== CW'(4) ||
            dout !== ((i == 4) ? 32'h04030201 : 32'h08070605))
          $display("FAIL full_word beat %0d got v=%b %h cnt=%0d want v=1 cnt=4",
                   i, vld_o, dout, cnt_o);
        else n_pass++;
      end else begin
        n_checks++;
        if (vld_o !== 1'b0) $display("FAIL full_idle beat %0d got v=%b want 0", i, vld_o);
        else n_pass++;
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, DW'(8'h15 + i), 1'b0, 1'b0);
      n_checks++;
      if (pre_ready !== 1'b1) $display("FAIL bp_ready lane %0d got %b want 1", i, pre_ready);
      else n_pass++;
      n_checks++;
      if (vld_o !== 1'b1 || dout !== 32'h14131211 || cnt_o !== CW'(4))
        $display("FAIL bp_hold got v=%b %h cnt=%0d want v=1 14131211 cnt=4",
                 vld_o, dout, cnt_o);
      else n_pass++;
    end
    cyc(1'b1, 8'h18, 1'b0, 1'b0);
    n_checks++;
    if (pre_ready !== 1'b0) $display("FAIL bp_last_stall got ready=%b want 0", pre_ready);
    else n_pass++;
    n_checks++;
    if (dout !== 32'h14131211) $display("FAIL bp_hold2 got %h want 14131211", dout);
    else n_pass++;
    cyc(1'b1, 8'h18, 1'b0, 1'b1);
    n_checks++;
    if (pre_ready !== 1'b1) $display("FAIL bp_release got ready=%b want 1", pre_ready);
    else n_pass++;
    n_checks++;
    if (vld_o !== 1'b1 || dout !== 32'h18171615 || cnt_o !== CW'(4))
      $display("FAIL bp_word2 got v=%b %h cnt=%0d want v=1 18171615 cnt=4", vld_o, dout, cnt_o);
    else n_pass++;
    cyc(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (vld_o !== 1'b0) $display("FAIL bp_drain got v=%b want 0", vld_o);
    else n_pass++;
  endtask

  task automatic test_flush_free();
    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    cyc(1'b1, 8'hBB, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (vld_o !== 1'b1 || dout !== 32'h0000BBAA || cnt_o !== CW'(2))
      $display("FAIL flush_free got v=%b %h cnt=%0d want v=1 0000bbaa cnt=2", vld_o, dout, cnt_o);
    else n_pass++;
    for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b0, 1'b1);
    n_checks++;
    if (vld_o !== 1'b1 || dout !== 32'h04030201 || cnt_o !== CW'(4))
      $display("FAIL flush_after got v=%b %h cnt=%0d want v=1 04030201 cnt=4", vld_o, dout, cnt_o);
    else n_pass++;
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_flush_stalled();
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'h21 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b1, 1'b0);
    n_checks++;
    if (pre_ready !== 1'b1) $display("FAIL fs_accept_c3 got ready=%b want 1", pre_ready);
    else n_pass++;
    n_checks++;
    if (vld_o !== 1'b1 || dout !== 32'h24232221)
      $display("FAIL fs_stalled got v=%b %h want v=1 24232221", vld_o, dout);
    else n_pass++;
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    n_checks++;
    if (pre_ready !== 1'b0) $display("FAIL fs_pend_ready got %b want 0", pre_ready);
    else n_pass++;
    cyc(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (pre_ready !== 1'b0) $display("FAIL fs_pend_ready2 got %b want 0", pre_ready);
    else n_pass++;
    n_checks++;
    if (vld_o !== 1'b1 || dout !== 32'h00C3C2C1 || cnt_o !== CW'(3))
      $display("FAIL fs_partial got v=%b %h cnt=%0d want v=1 00c3c2c1 cnt=3", vld_o, dout, cnt_o);
    else n_pass++;
    cyc(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (pre_ready !== 1'b1 || vld_o !== 1'b0)
      $display("FAIL fs_recover got ready=%b v=%b want ready=1 v=0", pre_ready, vld_o);
    else n_pass++;
  endtask

  task automatic test_flush_edges();
    cyc(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (vld_o !== 1'b0) $display("FAIL fe_empty got v=%b want 0", vld_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(8'h31 + i), 1'b0, 1'b1);
    cyc(1'b1, 8'h34, 1'b1, 1'b1);
    n_checks++;
    if (vld_o !== 1'b1 || dout !== 32'h34333231 || cnt_o !== CW'(4))
      $display("FAIL fe_full got v=%b %h cnt=%0d want v=1 34333231 cnt=4", vld_o, dout, cnt_o);
    else n_pass++;
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (vld_o !== 1'b0) $display("FAIL fe_no_extra got v=%b want 0", vld_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    cyc(1'b1, 8'h66, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (vld_o !== 1'b0) $display("FAIL rm_during got v=%b want 0", vld_o);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b1);
      if (i < 4) begin
        n_checks++;
        if (vld_o !== 1'b0) $display("FAIL rm_after beat %0d got v=%b want 0", i, vld_o);
        else n_pass++;
      end
    end
    n_checks++;
    if (vld_o !== 1'b1 || dout !== 32'h04030201 || cnt_o !== CW'(4))
      $display("FAIL rm_word got v=%b %h cnt=%0d want v=1 04030201 cnt=4", vld_o, dout, cnt_o);
    else n_pass++;
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(199) == 0);
      dv  = ($urandom_range(99) < 70);
      din = DW'($urandom);
      fl  = ($urandom_range(99) < 12);
      dr  = ($urandom_range(99) < 60);
      #1;
      n_checks++;
      if (rdy_o !== model_ready()) begin
        if (errs < 10) $display("FAIL rand_ready cyc %0d got %b want %b", c, rdy_o, model_ready());
        errs++;
      end else n_pass++;
      cyc(dv, din, fl, dr);
      n_checks++;
      if (vld_o !== m_valid ||
          (m_valid && (dout !== m_word || cnt_o !== CW'(m_count)))) begin
        if (errs < 10)
          $display("FAIL rand_out cyc %0d got v=%b %h cnt=%0d want v=%b %h cnt=%0d",
                   c, vld_o, dout, cnt_o, m_valid, m_word, m_count);
        errs++;
      end else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    dv       = 1'b0;
    din      = '0;
    fl       = 1'b0;
    dr       = 1'b0;
    m_pend   = 1'b0;
    m_valid  = 1'b0;
    m_word   = '0;
    m_count  = 0;
    test_reset();
    test_full_stream();
    test_backpressure();
    test_flush_free();
    test_flush_stalled();
    test_flush_edges();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Upstream neighbour of the stream skid buffer: it packs RATIO consecutive narrow valid/ready beats into one wide beat, lane 0 first (little-endian lane order).
- It has a flush input that emits a partially filled word together with a lane count.
- Its output is registered, and its output handshake matches the skid buffer's input, so the two chain directly.

Parameters:
- DATA_SIZE, 8, width of one input beat (bits); must be ≥1.
- RATIO, 4, input beats per output word; must be ≥2.
- CNT_W, $clog2(RATIO+1), width of count_o (derived, not overridden).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_clk_i  input  1  reset, synchronous, active-high.
- data_i  input  DATA_SIZE  input beat payload.
- data_valid_i  input  1  input beat valid.
- data_ready_o  output  1  input beat ready.
- flush_i  input  1  single-cycle request to emit the partial word.
- data_o  output  DATA_SIZE*RATIO  packed word; lane k = bits [k*DATA_SIZE +: DATA_SIZE].
- count_o  output  CNT_W  number of valid lanes in data_o (1..RATIO); qualified by data_valid_o.
- data_valid_o  output  1  output word valid.
- data_ready_i  input  1  downstream ready.

Behaviour:
Handshake and registers
- Input beat accepted when data_valid_i && data_ready_o. Output word consumed when data_valid_o && data_ready_i.
- Internal state:
  - acc, the accumulator, RATIO lanes.
  - lane counter cnt, 0..RATIO-1.
  - flush_pend flag.
  - Output register holding data_o, count_o and data_valid_o.
- slot_free = !data_valid_o || data_ready_i.

Reset
- Synchronous, active-high. While rst_clk_i is high at a clock edge: data_valid_o=0, data_o=0, count_o=0, cnt=0, acc=0, flush_pend=0.
- Reset mid-word discards the partial word silently. Reset while data_valid_o=1 drops the pending word.

Packing
- Accepted beat is written to lane cnt, then cnt increments.
- On the beat where cnt==RATIO-1, the full word (acc lanes 0..RATIO-2 plus the current beat in lane RATIO-1) loads the output register:
  - count_o=RATIO;
  - cnt wraps to 0;
  - acc is cleared.
- Latency: the output word is valid on the cycle after its last input beat is accepted.
- data_ready_o = !flush_pend && (cnt != RATIO-1 || slot_free).
  - This is combinational from data_ready_i only on the final-lane path.
  - Sustained throughput is 1 input beat per cycle when downstream is always ready.
- The output register holds data_o and count_o stable while data_valid_o && !data_ready_i.

Flush
- flush_i is sampled every cycle. Effective partial count P = cnt, plus 1 if a beat is accepted in the same cycle.
- If P==0: flush has no effect (no empty word is emitted).
- If P==RATIO: a normal full word is emitted and the flush is absorbed (no extra word).
- If 0<P<RATIO and slot_free:
  - the output register loads acc including the same-cycle beat;
  - unfilled lanes are zero;
  - count_o=P;
  - cnt=0, acc cleared.
- If 0<P<RATIO and !slot_free:
  - the same-cycle beat is still captured into acc;
  - flush_pend is set and data_ready_o is forced low;
  - on the first cycle slot_free is true, the partial word is emitted, then flush_pend clears.
- flush_i asserted while flush_pend=1 is ignored (no double emit).

States (encoded as cnt plus flush_pend)
- FILL: flush_pend=0.
- FLUSH_WAIT: flush_pend=1, exits to FILL when the partial word is emitted.

Invariants
- No beat is lost or duplicated.
- Lane order is preserved.
- data_valid_o never drops without a consuming handshake, except on reset.

Test Plan:
- Stream 0x01..0x08 with data_ready_i=1 every cycle (RATIO=4, DATA_SIZE=8) -> expect:
  - data_o=0x04030201, count_o=4, one cycle after beat 4;
  - then data_o=0x08070605, count_o=4;
  - data_ready_o stays 1 throughout.
- Stream 0x11..0x14 with data_ready_i=0 -> expect:
  - word 0x14131211 held stable;
  - data_ready_o=0 while cnt==3 after the next 3 beats 0x15..0x17 are accepted;
  - after data_ready_i=1, words 0x14131211 then 0x18171615 are emitted once beat 0x18 is accepted.
- Send 0xAA, 0xBB, then pulse flush_i with no beat, slot free -> expect data_o=0x0000BBAA, count_o=2, next cycle; then a following 0x01..0x04 yields 0x04030201.
- Two beats 0xC1, 0xC2 sit in acc while an output word is stalled (data_ready_i=0); pulse flush_i together with beat 0xC3 -> expect:
  - data_ready_o=0 from the next cycle;
  - after data_ready_i rises, the stalled word is consumed, then 0x00C3C2C1 is emitted with count_o=3;
  - data_ready_o returns to 1.
- Pulse flush_i with cnt==0 and no beat -> no output word. Pulse flush_i on the 4th beat of a word -> exactly one word, count_o=4.
- Accept 0x55, 0x66, assert rst_clk_i for 1 cycle, then send 0x01..0x04 -> expect data_valid_o=0 during and after reset, and the first word is 0x04030201 (no stale lanes).
